hyper_trans_seq: RTL and testbench
==================================

Name: hyper_trans_seq

Overview:
- Transaction sequencer and arbiter in front of the HyperBus/PSRAM command/address generator.
- Arbitrates between two uDMA-side requesters (ch0 = RX, ch1 = TX) with round-robin.
- Latches the winner's transaction fields and drives them to the CA generator.
- Then sequences the physical transaction: CS assertion, 3-beat CA phase, initial-latency wait, data-phase beat counting, and CS high time before the next transaction.

Parameters:
- LEN_W, 16, width of per-transaction word count.
- LAT_W, 5, width of latency configuration.
- CS_HIGH_CYC, 2, minimum cycles cs_n_o stays high between transactions (≥1).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; one clock, reset is asynchronous and active-high.
- req_i  in  2  per-channel request; held high until granted.
- gnt_o  out  2  one-cycle grant pulse, one-hot.
- ch_rw_i  in  2  per channel: 1 = read, 0 = write.
- ch_addr_space_i  in  2  per channel: 0 = memory, 1 = register.
- ch_burst_type_i  in  2  per channel: 0 = wrapped, 1 = linear.
- ch_addr_i  in  2x32  per-channel byte address.
- ch_len_i  in  2xLEN_W  per-channel 16-bit word count.
- mem_sel_i  in  2  device type: 00 = HyperRAM, 01 = HyperFlash, 10 = PSRAM, 11 = PSRAM 16-bit.
- latency_i  in  LAT_W  initial latency in clk_i cycles.
- fixed_lat_i  in  1  1 = always double latency.
- gen_rw_o, gen_addr_space_o, gen_burst_type_o  out  1 each  latched fields to the CA generator.
- gen_address_o  out  32  latched address to the CA generator.
- gen_cmd_addr_i  in  48  CA word returned by the generator (combinational from the gen_* outputs).
- cs_n_o  out  1  chip select, active-low.
- ca_valid_o  out  1  CA beat valid.
- ca_data_o  out  16  CA beat data.
- ca_ready_i  in  1  PHY accepts the CA beat.
- rwds_i  in  1  synchronised RWDS; sampled on acceptance of CA beat 0.
- data_en_o  out  1  data phase active.
- data_beat_i  in  1  one data word transferred this cycle.
- done_o  out  1  one-cycle pulse at end of data phase.
- done_ch_o  out  1  channel id that finished; valid with done_o.
- busy_o  out  1  state ≠ IDLE.

Behaviour:
- Reset values:
  - State IDLE, cs_n_o = 1.
  - All other outputs 0.
  - Round-robin pointer last = 1, so ch0 wins the first tie.
  - Reset mid-transaction aborts immediately: cs_n_o high, no done_o.
- States: IDLE, CA, LAT, DATA, CSHI.
- IDLE:
  - If any req_i, grant per round-robin. A single requester always wins. On a tie, the channel ≠ last wins.
  - gnt_o pulses in that same cycle. Fields are latched and last is updated.
  - Next state CA. Grant-to-cs_n_o-low latency is 1 cycle.
- CA:
  - cs_n_o = 0, ca_valid_o = 1, beat counter b = 0..2.
  - ca_data_o = gen_cmd_addr_i[47-16b -: 16], MSB first.
  - b advances only when ca_ready_i = 1. Data is held while stalled.
  - On acceptance of beat 0, capture dbl = fixed_lat_i | rwds_i.
  - On acceptance of beat 2, load lat_cnt = latency_i << dbl.
- Skip rules after beat 2:
  - Go directly to DATA if lat_cnt == 0.
  - Also go directly to DATA for a zero-latency register write: mem_sel_i == 00, addr_space = 1, rw = 0.
  - Otherwise go to LAT.
- LAT:
  - cs_n_o = 0. lat_cnt decrements every cycle.
  - Exit to DATA in the cycle lat_cnt == 1, so LAT occupies exactly N cycles.
- DATA:
  - cs_n_o = 0, data_en_o = 1.
  - rem is loaded with len. len == 0 is treated as 1.
  - rem decrements on data_beat_i. A beat when rem == 1 causes: done_o = 1, done_ch_o = channel, next state CSHI.
  - data_beat_i is ignored outside DATA.
- CSHI:
  - cs_n_o = 1 for exactly CS_HIGH_CYC cycles, then IDLE.
  - Requests arriving during CSHI wait. No grant is issued outside IDLE.
- Stability: gen_* outputs are held from grant until the next grant, so gen_cmd_addr_i is stable for the whole CA phase.
- mem_sel_i and latency_i must be static while busy_o = 1. They are not latched, except that latency is sampled at beat 2.

Decomposition:
- Shared package hyper_pkg:
  - State enum hyper_seq_state_e.
  - mem_sel encodings (MEM_HYPERRAM = 2'b00, MEM_HYPERFLASH = 2'b01, MEM_PSRAM = 2'b10, MEM_PSRAM16 = 2'b11).
  - CA_BEATS = 3.
  - Packed struct hyper_req_t {rw, addr_space, burst_type, addr[31:0], len[LEN_W-1:0]}.
- Sub-module hyper_rr_arb2: 2-input round-robin arbiter with pointer register. The FSM stays in the top level.

Test Plan:
- Single ch0 read:
  - Stimulus: addr 0x100, len 4, latency 6, fixed_lat 0, rwds 0, ca_ready 1, 4 beats.
  - Required response: gnt = 01; cs_n_o low 1 cycle later; 3 CA beats = gen word [47:32], [31:16], [15:0]; 6 LAT cycles; DATA until the 4th beat; done_o with done_ch_o = 0; cs_n_o high for 2 cycles.
- Latency doubling:
  - Stimulus: rwds_i = 1 at beat 0, latency 6.
  - Required response: exactly 12 LAT cycles. Repeat with fixed_lat_i = 1, rwds 0 → 12 cycles.
- Zero-latency register write:
  - Stimulus: HyperRAM (mem_sel 00), ch1 write, addr_space 1, len 1.
  - Required response: no LAT cycles; DATA entered the cycle after beat 2. With mem_sel = 10 the same request inserts the latency.
- Tie arbitration:
  - Stimulus: both req_i high from reset.
  - Required response: grants ch0, then ch1, then ch0. Grant only in IDLE after CSHI.
- CA stall:
  - Stimulus: ca_ready_i low 3 cycles during beat 1.
  - Required response: ca_data_o held stable; beat 2 follows; total CA = 6 cycles.
- Reset mid-DATA:
  - Stimulus: assert rst_i with rem = 3.
  - Required response: cs_n_o = 1 asynchronously; busy_o = 0; no done_o. A following ch1-only request is granted.

Source files
------------

// File: rtl/hyper_pkg.sv
// Shared types and encodings for the HyperBus/PSRAM transaction sequencer.
package hyper_pkg;

    localparam int unsigned HYPER_LEN_W = 16;
    localparam int unsigned CA_BEATS    = 3;

    localparam logic [1:0] MEM_HYPERRAM   = 2'b00;
    localparam logic [1:0] MEM_HYPERFLASH = 2'b01;
    localparam logic [1:0] MEM_PSRAM      = 2'b10;
    localparam logic [1:0] MEM_PSRAM16    = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CA,
        ST_LAT,
        ST_DATA,
        ST_CSHI
    } hyper_seq_state_e;

    typedef struct packed {
        logic                   rw;
        logic                   addr_space;
        logic                   burst_type;
        logic [31:0]            addr;
        logic [HYPER_LEN_W-1:0] len;
    } hyper_req_t;

endpackage

// File: rtl/hyper_rr_arb2.sv
// Two-requester round-robin arbiter; on a tie the channel that did not win last goes first.
module hyper_rr_arb2 (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [1:0] i_req,
    input  logic       i_en,
    output logic [1:0] o_gnt
);

    logic r_last;

    always_comb begin
        o_gnt = 2'b00;
        case (i_req)
            2'b01:   o_gnt = 2'b01;
            2'b10:   o_gnt = 2'b10;
            2'b11:   o_gnt = r_last ? 2'b01 : 2'b10;
            default: o_gnt = 2'b00;
        endcase
    end

    // Reset to 1 so channel 0 wins the first tie.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_last <= 1'b1;
        end else if (i_en && (|i_req)) begin
            r_last <= o_gnt[1];
        end
    end

endmodule

// File: rtl/hyper_trans_seq.sv
// Arbitrates two uDMA channels and sequences a HyperBus transaction: CS, 3 CA beats,
// initial latency, data beats and CS high time.
module hyper_trans_seq
    import hyper_pkg::*;
#(
    parameter int unsigned LEN_W       = HYPER_LEN_W,
    parameter int unsigned LAT_W       = 5,
    parameter int unsigned CS_HIGH_CYC = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [1:0]            req_i,
    output logic [1:0]            gnt_o,
    input  logic [1:0]            ch_rw_i,
    input  logic [1:0]            ch_addr_space_i,
    input  logic [1:0]            ch_burst_type_i,
    input  logic [1:0][31:0]      ch_addr_i,
    input  logic [1:0][LEN_W-1:0] ch_len_i,
    input  logic [1:0]            mem_sel_i,
    input  logic [LAT_W-1:0]      latency_i,
    input  logic                  fixed_lat_i,
    output logic                  gen_rw_o,
    output logic                  gen_addr_space_o,
    output logic                  gen_burst_type_o,
    output logic [31:0]           gen_address_o,
    input  logic [47:0]           gen_cmd_addr_i,
    output logic                  cs_n_o,
    output logic                  ca_valid_o,
    output logic [15:0]           ca_data_o,
    input  logic                  ca_ready_i,
    input  logic                  rwds_i,
    output logic                  data_en_o,
    input  logic                  data_beat_i,
    output logic                  done_o,
    output logic                  done_ch_o,
    output logic                  busy_o
);

    localparam int unsigned CNT_W = LAT_W + 1;
    localparam int unsigned CS_W  = $clog2(CS_HIGH_CYC + 1);

    hyper_seq_state_e r_state;
    hyper_req_t       r_req;
    logic             r_ch;
    logic             r_dbl;
    logic [1:0]       r_beat;
    logic [CNT_W-1:0] r_lat_cnt;
    logic [LEN_W-1:0] r_rem;
    logic [CS_W-1:0]  r_cs_cnt;

    logic             w_idle;
    logic [1:0]       w_arb_gnt;
    logic             w_ch;
    hyper_req_t       w_req;
    logic [CNT_W-1:0] w_lat_load;
    logic             w_skip;
    logic [LEN_W-1:0] w_rem_load;

    assign w_idle = (r_state == ST_IDLE);

    hyper_rr_arb2 u_arb (
        .i_clk (clk_i),
        .i_rst (rst_i),
        .i_req (req_i),
        .i_en  (w_idle),
        .o_gnt (w_arb_gnt)
    );

    assign gnt_o = w_idle ? w_arb_gnt : 2'b00;
    assign w_ch  = w_arb_gnt[1];

    assign w_req.rw         = ch_rw_i[w_ch];
    assign w_req.addr_space = ch_addr_space_i[w_ch];
    assign w_req.burst_type = ch_burst_type_i[w_ch];
    assign w_req.addr       = ch_addr_i[w_ch];
    assign w_req.len        = HYPER_LEN_W'(ch_len_i[w_ch]);

    // Latency is doubled when RWDS was high on beat 0 or the device runs fixed double latency.
    assign w_lat_load = CNT_W'(latency_i) << r_dbl;
    assign w_skip     = (w_lat_load == '0) ||
                        ((mem_sel_i == MEM_HYPERRAM) && r_req.addr_space && !r_req.rw);
    assign w_rem_load = (r_req.len == '0) ? LEN_W'(1) : LEN_W'(r_req.len);

    assign gen_rw_o         = r_req.rw;
    assign gen_addr_space_o = r_req.addr_space;
    assign gen_burst_type_o = r_req.burst_type;
    assign gen_address_o    = r_req.addr;

    // CA beats go out MSB-first from the generator word; it is stable for the whole CA phase.
    always_comb begin
        ca_data_o = 16'h0000;
        if (ca_valid_o) begin
            case (r_beat)
                2'd0:    ca_data_o = gen_cmd_addr_i[47:32];
                2'd1:    ca_data_o = gen_cmd_addr_i[31:16];
                default: ca_data_o = gen_cmd_addr_i[15:0];
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= ST_IDLE;
            r_req      <= '0;
            r_ch       <= 1'b0;
            r_dbl      <= 1'b0;
            r_beat     <= 2'd0;
            r_lat_cnt  <= '0;
            r_rem      <= '0;
            r_cs_cnt   <= '0;
            cs_n_o     <= 1'b1;
            ca_valid_o <= 1'b0;
            data_en_o  <= 1'b0;
            done_o     <= 1'b0;
            done_ch_o  <= 1'b0;
            busy_o     <= 1'b0;
        end else begin
            done_o    <= 1'b0;
            done_ch_o <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (|req_i) begin
                        r_req      <= w_req;
                        r_ch       <= w_ch;
                        r_beat     <= 2'd0;
                        r_dbl      <= 1'b0;
                        cs_n_o     <= 1'b0;
                        ca_valid_o <= 1'b1;
                        busy_o     <= 1'b1;
                        r_state    <= ST_CA;
                    end
                end
                ST_CA: begin
                    if (ca_ready_i) begin
                        if (r_beat == 2'd0) begin
                            r_dbl <= fixed_lat_i | rwds_i;
                        end
                        if (r_beat == 2'(CA_BEATS - 1)) begin
                            ca_valid_o <= 1'b0;
                            r_lat_cnt  <= w_lat_load;
                            if (w_skip) begin
                                r_rem     <= w_rem_load;
                                data_en_o <= 1'b1;
                                r_state   <= ST_DATA;
                            end else begin
                                r_state <= ST_LAT;
                            end
                        end else begin
                            r_beat <= r_beat + 2'd1;
                        end
                    end
                end
                ST_LAT: begin
                    r_lat_cnt <= r_lat_cnt - CNT_W'(1);
                    if (r_lat_cnt == CNT_W'(1)) begin
                        r_rem     <= w_rem_load;
                        data_en_o <= 1'b1;
                        r_state   <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (data_beat_i) begin
                        if (r_rem == LEN_W'(1)) begin
                            done_o    <= 1'b1;
                            done_ch_o <= r_ch;
                            data_en_o <= 1'b0;
                            cs_n_o    <= 1'b1;
                            r_cs_cnt  <= CS_W'(CS_HIGH_CYC);
                            r_state   <= ST_CSHI;
                        end else begin
                            r_rem <= r_rem - LEN_W'(1);
                        end
                    end
                end
                ST_CSHI: begin
                    if (r_cs_cnt == CS_W'(1)) begin
                        busy_o  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_cs_cnt <= r_cs_cnt - CS_W'(1);
                    end
                end
                default: begin
                    cs_n_o  <= 1'b1;
                    busy_o  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hyper_trans_seq.sv
// Directed plus randomized bench for hyper_trans_seq against a transaction-level model.
module tb_hyper_trans_seq;

    localparam int unsigned LAT_W = 5;
    localparam int unsigned CSH   = 2;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic [1:0]       req_i;
    logic [1:0]       gnt_o;
    logic [1:0]       ch_rw, ch_asp, ch_bt;
    logic [1:0][31:0] ch_addr;
    logic [1:0][15:0] ch_len;
    logic [1:0]       mem_sel_i;
    logic [LAT_W-1:0] latency_i;
    logic             fixed_lat_i;
    logic             gen_rw_o, gen_addr_space_o, gen_burst_type_o;
    logic [31:0]      gen_address_o;
    logic [47:0]      gen_cmd_addr_i;
    logic             cs_n_o, ca_valid_o, ca_ready_i, rwds_i;
    logic [15:0]      ca_data_o;
    logic             data_en_o, data_beat_i, done_o, done_ch_o, busy_o;

    int checks   = 0;
    int failures = 0;

    always #5 clk_i = ~clk_i;

    // Stand-in CA generator: any fixed mapping of the latched fields works for checking.
    function automatic logic [47:0] gen_word(input logic rw, input logic asp, input logic bt,
                                             input logic [31:0] a);
        return {rw, asp, bt, a[31:3], 13'h0000, a[2:0]};
    endfunction

    assign gen_cmd_addr_i = gen_word(gen_rw_o, gen_addr_space_o, gen_burst_type_o, gen_address_o);

    hyper_trans_seq #(.LEN_W(16), .LAT_W(LAT_W), .CS_HIGH_CYC(CSH)) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .req_i            (req_i),
        .gnt_o            (gnt_o),
        .ch_rw_i          (ch_rw),
        .ch_addr_space_i  (ch_asp),
        .ch_burst_type_i  (ch_bt),
        .ch_addr_i        (ch_addr),
        .ch_len_i         (ch_len),
        .mem_sel_i        (mem_sel_i),
        .latency_i        (latency_i),
        .fixed_lat_i      (fixed_lat_i),
        .gen_rw_o         (gen_rw_o),
        .gen_addr_space_o (gen_addr_space_o),
        .gen_burst_type_o (gen_burst_type_o),
        .gen_address_o    (gen_address_o),
        .gen_cmd_addr_i   (gen_cmd_addr_i),
        .cs_n_o           (cs_n_o),
        .ca_valid_o       (ca_valid_o),
        .ca_data_o        (ca_data_o),
        .ca_ready_i       (ca_ready_i),
        .rwds_i           (rwds_i),
        .data_en_o        (data_en_o),
        .data_beat_i      (data_beat_i),
        .done_o           (done_o),
        .done_ch_o        (done_ch_o),
        .busy_o           (busy_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_ch(input int ch, input logic rw, input logic asp, input logic bt,
                          input logic [31:0] a, input logic [15:0] len);
        ch_rw[ch]   = rw;
        ch_asp[ch]  = asp;
        ch_bt[ch]   = bt;
        ch_addr[ch] = a;
        ch_len[ch]  = len;
    endtask

    // Runs one full transaction from a pending request and checks every phase against the model.
    task automatic do_txn(input int ch, input int stall, input logic rwds_v, input logic fixed_v);
        logic [47:0] w;
        int exp_lat, exp_beats, n, beats, ca_cyc, hold;
        logic gbad;
        w         = gen_word(ch_rw[ch], ch_asp[ch], ch_bt[ch], ch_addr[ch]);
        exp_lat   = (fixed_v | rwds_v) ? 2 * int'(latency_i) : int'(latency_i);
        if (mem_sel_i == 2'b00 && ch_asp[ch] && !ch_rw[ch]) exp_lat = 0;
        exp_beats = (ch_len[ch] == 16'd0) ? 1 : int'(ch_len[ch]);
        fixed_lat_i = fixed_v;
        ca_ready_i  = 1'b1;

        for (int i = 0; i < 40; i++) begin
            #1;
            if (gnt_o != 2'b00) break;
            tick();
        end
        chk("gnt", 64'(gnt_o), 64'(2'b01 << ch));
        chk("gnt_in_idle", 64'(busy_o), 64'd0);
        tick();
        req_i[ch] = 1'b0;
        chk("cs_low_after_gnt", 64'(cs_n_o), 64'd0);
        chk("gen_address", 64'(gen_address_o), 64'(ch_addr[ch]));

        ca_cyc = 0;
        for (int b = 0; b < 3; b++) begin
            hold = (b == 1) ? stall : 0;
            for (int h = 0; h <= hold; h++) begin
                ca_ready_i  = (h == hold);
                rwds_i      = (b == 0) ? rwds_v : !rwds_v;
                data_beat_i = 1'($urandom_range(0, 1));
                #1;
                chk("ca_data", 64'(ca_data_o), 64'(w[47 - 16 * b -: 16]));
                if (ca_valid_o) ca_cyc++;
                tick();
            end
        end
        rwds_i = 1'b0;
        chk("ca_cycles", 64'(ca_cyc), 64'(3 + stall));

        n = 0;
        for (int i = 0; i < 200 && data_en_o !== 1'b1; i++) begin
            if (!cs_n_o && !ca_valid_o) n++;
            data_beat_i = 1'($urandom_range(0, 1));
            tick();
        end
        chk("lat_cycles", 64'(n), 64'(exp_lat));
        chk("data_en", 64'(data_en_o), 64'd1);

        beats = 0;
        for (int i = 0; i < 500 && beats < exp_beats; i++) begin
            data_beat_i = 1'($urandom_range(0, 1));
            if (data_beat_i) beats++;
            if (done_o) chk("early_done", 64'(done_o), 64'd0);
            tick();
        end
        data_beat_i = 1'b0;
        chk("done", 64'(done_o), 64'd1);
        chk("done_ch", 64'(done_ch_o), 64'(ch));
        chk("data_en_off", 64'(data_en_o), 64'd0);

        n    = 0;
        gbad = 1'b0;
        for (int i = 0; i < 20 && busy_o === 1'b1; i++) begin
            if (cs_n_o) n++;
            #1;
            if (gnt_o !== 2'b00) gbad = 1'b1;
            tick();
        end
        chk("cshi_cycles", 64'(n), 64'(CSH));
        chk("no_gnt_when_busy", 64'(gbad), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i = 1'b1; req_i = 2'b00; ch_rw = '0; ch_asp = '0; ch_bt = '0; ch_addr = '0;
        ch_len = '0; mem_sel_i = 2'b00; latency_i = '0; fixed_lat_i = 1'b0;
        ca_ready_i = 1'b1; rwds_i = 1'b0; data_beat_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_cs_n", 64'(cs_n_o), 64'd1);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_outs", 64'({ca_valid_o, data_en_o, done_o, done_ch_o, gnt_o}), 64'd0);
        rst_i = 1'b0;
        tick();

        // Tie from reset: ch0, ch1, ch0.
        set_ch(0, 1'b1, 1'b0, 1'b1, 32'h0000_0100, 16'd4);
        set_ch(1, 1'b0, 1'b0, 1'b0, 32'h0000_2A05, 16'd2);
        latency_i = 5'd6;
        req_i = 2'b11;
        do_txn(0, 0, 1'b0, 1'b0);
        req_i = 2'b11;
        do_txn(1, 0, 1'b0, 1'b0);
        req_i = 2'b11;
        do_txn(0, 0, 1'b0, 1'b0);
        req_i = 2'b00;

        // Latency doubling via RWDS, then via fixed latency.
        req_i[0] = 1'b1; do_txn(0, 0, 1'b1, 1'b0);
        req_i[0] = 1'b1; do_txn(0, 0, 1'b0, 1'b1);

        // Zero-latency register write on HyperRAM, then the same on PSRAM.
        set_ch(1, 1'b0, 1'b1, 1'b0, 32'h0000_0800, 16'd1);
        mem_sel_i = 2'b00; req_i[1] = 1'b1; do_txn(1, 0, 1'b0, 1'b0);
        mem_sel_i = 2'b10; req_i[1] = 1'b1; do_txn(1, 0, 1'b0, 1'b0);

        // CA stall of three cycles on beat 1.
        mem_sel_i = 2'b00;
        req_i[0] = 1'b1; do_txn(0, 3, 1'b0, 1'b0);

        // Randomized single-channel transactions.
        for (int k = 0; k < 8; k++) begin
            int c;
            c = int'($urandom_range(0, 1));
            set_ch(c, 1'($urandom), 1'($urandom), 1'($urandom), $urandom, 16'($urandom_range(0, 5)));
            mem_sel_i = 2'($urandom);
            latency_i = LAT_W'($urandom_range(0, 7));
            req_i[c]  = 1'b1;
            do_txn(c, int'($urandom_range(0, 2)), 1'($urandom), 1'($urandom));
        end

        // Reset mid-DATA with three words remaining.
        set_ch(0, 1'b1, 1'b0, 1'b1, 32'h0000_4000, 16'd5);
        latency_i = 5'd2; mem_sel_i = 2'b00; fixed_lat_i = 1'b0; ca_ready_i = 1'b1;
        req_i = 2'b01;
        for (int i = 0; i < 40 && gnt_o == 2'b00; i++) tick();
        tick();
        req_i = 2'b00;
        for (int i = 0; i < 40 && data_en_o !== 1'b1; i++) tick();
        data_beat_i = 1'b1;
        tick();
        tick();
        data_beat_i = 1'b0;
        chk("pre_rst_data_en", 64'(data_en_o), 64'd1);
        #2 rst_i = 1'b1;
        #1;
        chk("mid_rst_cs_n", 64'(cs_n_o), 64'd1);
        chk("mid_rst_busy", 64'(busy_o), 64'd0);
        chk("mid_rst_done", 64'(done_o), 64'd0);
        tick();
        rst_i = 1'b0;
        tick();
        chk("post_rst_done", 64'(done_o), 64'd0);
        set_ch(1, 1'b1, 1'b0, 1'b0, 32'h0000_0013, 16'd3);
        req_i[1] = 1'b1;
        do_txn(1, 0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
